// File: rtl/wr_word_writer.sv
// wr_word_writer: captures packed 32-bit words from the layer-2 packer, buffers
// them in a small FIFO and drains them to memory through a valid/ack write port
// at sequential addresses starting from a per-frame base.
//
// Ports:
//   clk        rising-edge clock
//   rstWRn     asynchronous active-low reset
//   start      starts a frame (IDLE only); baseAddr sampled with it
//   baseAddr   first write address of the frame
//   inWord     packed word from the packer
//   inFull     packer full flag (high until the packer is cleared)
//   inLast     marks inWord as the frame's last word
//   clrPack    one-cycle pulse clearing the packer after a capture
//   memWrEn    write request valid (FIFO non-empty)
//   memAddr    write address
//   memData    write data (FIFO head)
//   memAck     memory accepts the request this cycle
//   busy       high while a frame is in progress (RUN or DRAIN)
//   done       one-cycle pulse after the last word is acknowledged
//   overflow   sticky: packer word presented while the FIFO was full
//   level      FIFO occupancy
//
// Build option: define WR_BYTE_SWAP_EN to byte-reverse memData so the first
// byte the packer received lands in the LSB.
module wr_word_writer #(
   parameter int DEPTH     = 4,
   parameter int AW        = 10,
   parameter int MEM_WORDS = 1024
) (
   input  logic                         clk,
   input  logic                         rstWRn,
   input  logic                         start,
   input  logic [AW-1:0]                baseAddr,
   input  logic [31:0]                  inWord,
   input  logic                         inFull,
   input  logic                         inLast,
   output logic                         clrPack,
   output logic                         memWrEn,
   output logic [AW-1:0]                memAddr,
   output logic [31:0]                  memData,
   input  logic                         memAck,
   output logic                         busy,
   output logic                         done,
   output logic                         overflow,
   output logic [$clog2(DEPTH+1)-1:0]   level
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state, nextState;

   logic [32:0]   fifo [DEPTH];
   logic [PW-1:0] rdPtr, wrPtr;
   logic          fifoFull, push, pop, headLast, ovfSet, wantCap;
   logic [31:0]   head;

   assign fifoFull = level == LW'(DEPTH);
   assign memWrEn  = level != '0;
   assign pop      = memWrEn && memAck;
   assign headLast = fifo[rdPtr][32];
   // Head is masked while empty so memData reads 0 rather than stale storage.
   assign head     = memWrEn ? fifo[rdPtr][31:0] : '0;
   // While clrPack is high the packer's full flag is still the old one.
   assign wantCap  = state == RUN && inFull && !clrPack;
   // A full FIFO still accepts a word when the head pops in the same cycle.
   assign push     = wantCap && (!fifoFull || pop);
   assign ovfSet   = wantCap && fifoFull && !pop;
   assign busy     = state != IDLE;

`ifdef WR_BYTE_SWAP_EN
   assign memData = {head[7:0], head[15:8], head[23:16], head[31:24]};
`else
   assign memData = head;
`endif

   always_ff @(posedge clk or negedge rstWRn)
      if (!rstWRn) state <= IDLE;
      else         state <= nextState;

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (start) nextState = RUN;
         RUN:     if (push && inLast) nextState = DRAIN;
         DRAIN:   if (pop && headLast) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk)
      if (push) fifo[wrPtr] <= {inLast, inWord};

   always_ff @(posedge clk or negedge rstWRn)
      if (!rstWRn) begin
         rdPtr    <= '0;
         wrPtr    <= '0;
         level    <= '0;
         clrPack  <= 1'b0;
         done     <= 1'b0;
         overflow <= 1'b0;
         memAddr  <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + PW'(1);
         if (pop)  rdPtr <= rdPtr + PW'(1);
         level   <= level + LW'(push) - LW'(pop);
         clrPack <= push;
         done    <= pop && headLast;
         if (state == IDLE && start) begin
            memAddr  <= baseAddr;
            overflow <= 1'b0;
         end else begin
            if (pop) memAddr <= (memAddr == AW'(MEM_WORDS-1)) ? '0 : memAddr + AW'(1);
            if (ovfSet) overflow <= 1'b1;
         end
      end
endmodule

// File: tb/tb_wr_word_writer.sv
// tb_wr_word_writer: table-driven and directed self-checking bench for wr_word_writer.
module tb_wr_word_writer;
   logic        clk = 1'b0;
   logic        rstWRn, start, inFull, inLast, memAck;
   logic [9:0]  baseAddr;
   logic [31:0] inWord;
   logic        clrPack, memWrEn, busy, done, overflow;
   logic [9:0]  memAddr;
   logic [31:0] memData;
   logic [2:0]  level;
   int          nPass = 0, nTotal = 0;

   wr_word_writer dut (
      .clk(clk), .rstWRn(rstWRn), .start(start), .baseAddr(baseAddr),
      .inWord(inWord), .inFull(inFull), .inLast(inLast), .clrPack(clrPack),
      .memWrEn(memWrEn), .memAddr(memAddr), .memData(memData), .memAck(memAck),
      .busy(busy), .done(done), .overflow(overflow), .level(level)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic [9:0]  base;
      logic [31:0] w;
      logic        full, last, ack;
      logic        eClr, eWr;
      logic [9:0]  eAddr;
      logic [31:0] eData;
      logic        eBusy, eDone, eOvf;
      logic [2:0]  eLvl;
   } vec_t;
   vec_t tbl [7];

   function automatic logic [31:0] expData(input logic [31:0] w);
`ifdef WR_BYTE_SWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nTotal++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
      else nPass++;
   endtask

   task automatic chkAll(input string nm, input logic eClr, input logic eWr,
                         input logic [9:0] eAddr, input logic [31:0] eData,
                         input logic eBusy, input logic eDone, input logic eOvf,
                         input logic [2:0] eLvl);
      chk({nm, ".clrPack"}, 32'(clrPack), 32'(eClr));
      chk({nm, ".memWrEn"}, 32'(memWrEn), 32'(eWr));
      chk({nm, ".memAddr"}, 32'(memAddr), 32'(eAddr));
      chk({nm, ".memData"}, memData, eData);
      chk({nm, ".busy"}, 32'(busy), 32'(eBusy));
      chk({nm, ".done"}, 32'(done), 32'(eDone));
      chk({nm, ".overflow"}, 32'(overflow), 32'(eOvf));
      chk({nm, ".level"}, 32'(level), 32'(eLvl));
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Behaves like the packer: holds inFull until clrPack, keeps the stale flag
   // for the clrPack cycle, then drops it.
   task automatic sendWord(input logic [31:0] w, input logic l);
      logic got;
      got = 1'b0;
      inWord = w;
      inLast = l;
      inFull = 1'b1;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         got = clrPack;
      end
      chk("capture", 32'(got), 32'd1);
      tick();
      inFull = 1'b0;
      inLast = 1'b0;
   endtask

   task automatic startFrame(input logic [9:0] b);
      start = 1'b1;
      baseAddr = b;
      tick();
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic seen;
      rstWRn = 1'b0; start = 1'b0; inFull = 1'b0; inLast = 1'b0; memAck = 1'b0;
      baseAddr = '0; inWord = '0;
      #12;
      chkAll("inReset", 0, 0, 10'h0, 32'h0, 0, 0, 0, 3'd0);
      @(posedge clk);
      #1 rstWRn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chkAll("idle", 0, 0, 10'h0, 32'h0, 0, 0, 0, 3'd0);
      end

      // Two-word frame with memAck tied high.
      tbl[0] = '{1'b1, 10'h010, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h010, 32'h0,                 1'b1, 1'b0, 1'b0, 3'd0};
      tbl[1] = '{1'b0, 10'h010, 32'h11223344, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 10'h010, expData(32'h11223344), 1'b1, 1'b0, 1'b0, 3'd1};
      tbl[2] = '{1'b0, 10'h010, 32'h11223344, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h011, 32'h0,                 1'b1, 1'b0, 1'b0, 3'd0};
      tbl[3] = '{1'b0, 10'h010, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h011, 32'h0,                 1'b1, 1'b0, 1'b0, 3'd0};
      tbl[4] = '{1'b0, 10'h010, 32'hAABBCCDD, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'h011, expData(32'hAABBCCDD), 1'b1, 1'b0, 1'b0, 3'd1};
      tbl[5] = '{1'b0, 10'h010, 32'hAABBCCDD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'h012, 32'h0,                 1'b0, 1'b1, 1'b0, 3'd0};
      tbl[6] = '{1'b0, 10'h010, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h012, 32'h0,                 1'b0, 1'b0, 1'b0, 3'd0};
      for (int i = 0; i < 7; i++) begin
         start = tbl[i].st; baseAddr = tbl[i].base; inWord = tbl[i].w;
         inFull = tbl[i].full; inLast = tbl[i].last; memAck = tbl[i].ack;
         tick();
         chkAll($sformatf("vec%0d", i), tbl[i].eClr, tbl[i].eWr, tbl[i].eAddr, tbl[i].eData,
                tbl[i].eBusy, tbl[i].eDone, tbl[i].eOvf, tbl[i].eLvl);
      end
      start = 1'b0; inFull = 1'b0; inLast = 1'b0;

      // Memory backpressure: three words wait while memAck is low.
      memAck = 1'b0;
      startFrame(10'h100);
      sendWord(32'hA0000001, 1'b0);
      sendWord(32'hA0000002, 1'b0);
      sendWord(32'hA0000003, 1'b1);
      chkAll("bpWait", 0, 1, 10'h100, expData(32'hA0000001), 1, 0, 0, 3'd3);
      tick();
      tick();
      chkAll("bpStable", 0, 1, 10'h100, expData(32'hA0000001), 1, 0, 0, 3'd3);
      memAck = 1'b1;
      tick();
      chkAll("bpPop1", 0, 1, 10'h101, expData(32'hA0000002), 1, 0, 0, 3'd2);
      tick();
      chkAll("bpPop2", 0, 1, 10'h102, expData(32'hA0000003), 1, 0, 0, 3'd1);
      tick();
      chkAll("bpDone", 0, 0, 10'h103, 32'h0, 0, 1, 0, 3'd0);
      tick();
      chk("bpDonePulse", 32'(done), 32'd0);

      // FIFO full: fifth word withheld and flagged until a pop frees space.
      memAck = 1'b0;
      startFrame(10'h200);
      sendWord(32'hB0000001, 1'b0);
      sendWord(32'hB0000002, 1'b0);
      sendWord(32'hB0000003, 1'b0);
      sendWord(32'hB0000004, 1'b0);
      chkAll("ffFull", 0, 1, 10'h200, expData(32'hB0000001), 1, 0, 0, 3'd4);
      inWord = 32'hB0000005; inLast = 1'b1; inFull = 1'b1;
      tick();
      chkAll("ffOvf", 0, 1, 10'h200, expData(32'hB0000001), 1, 0, 1, 3'd4);
      tick();
      chkAll("ffRetry", 0, 1, 10'h200, expData(32'hB0000001), 1, 0, 1, 3'd4);
      memAck = 1'b1;
      tick();
      chkAll("ffCapture", 1, 1, 10'h201, expData(32'hB0000002), 1, 0, 1, 3'd4);
      inFull = 1'b0; inLast = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         tick();
         seen = done;
      end
      chk("ffDoneSeen", 32'(seen), 32'd1);
      chkAll("ffEnd", 0, 0, 10'h205, 32'h0, 0, 1, 1, 3'd0);

      // Address wrap; this start also clears the sticky overflow.
      memAck = 1'b0;
      startFrame(10'h3FF);
      chk("ovfCleared", 32'(overflow), 32'd0);
      sendWord(32'hC0000001, 1'b0);
      sendWord(32'hC0000002, 1'b1);
      chkAll("wrap0", 0, 1, 10'h3FF, expData(32'hC0000001), 1, 0, 0, 3'd2);
      memAck = 1'b1;
      tick();
      chkAll("wrap1", 0, 1, 10'h000, expData(32'hC0000002), 1, 0, 0, 3'd1);
      tick();
      chkAll("wrapDone", 0, 0, 10'h001, 32'h0, 0, 1, 0, 3'd0);

      // Asynchronous reset mid-frame, then a fresh frame.
      memAck = 1'b0;
      startFrame(10'h020);
      sendWord(32'hD0000001, 1'b0);
      sendWord(32'hD0000002, 1'b0);
      sendWord(32'hD0000003, 1'b0);
      chk("arLevel", 32'(level), 32'd3);
      @(posedge clk);
      #3 rstWRn = 1'b0;
      #1;
      chkAll("arAsync", 0, 0, 10'h0, 32'h0, 0, 0, 0, 3'd0);
      @(posedge clk);
      #1 rstWRn = 1'b1;
      memAck = 1'b1;
      startFrame(10'h040);
      inWord = 32'h11223344; inLast = 1'b1; inFull = 1'b1;
      tick();
      chkAll("arWrite", 1, 1, 10'h040, expData(32'h11223344), 1, 0, 0, 3'd1);
      tick();
      chkAll("arDone", 0, 0, 10'h041, 32'h0, 0, 1, 0, 3'd0);
      inFull = 1'b0; inLast = 1'b0;
      tick();

      $display("%0d/%0d checks passed", nPass, nTotal);
      $finish;
   end
endmodule
